// File: rtl/bram_pkg.sv
// Shared types and constants for the BRAM request adapter.
// Optional statistics counters: define BRAM_REQ_ADAPTER_STATS_EN.
`timescale 1ns/1ps
package bram_pkg;

    localparam int unsigned WDATA     = 8;
    localparam int unsigned RSP_DEPTH = 2;
    localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int unsigned STATS_W   = 16;

    typedef struct packed {
        logic [WDATA-1:0] data;
        logic             err;
    } rsp_t;

    function automatic logic [STATS_W-1:0] sat_inc(
        input logic [STATS_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bram_req_adapter_if.sv
// Request/response handshake bundle between bus masters and the adapter.
// master = bus master side, slave = adapter side.
`timescale 1ns/1ps
interface bram_req_adapter_if #(
    parameter int unsigned Waddr = 32,
    parameter int unsigned Wdata = 8
);
    logic             REQ_VALID;
    logic             REQ_READY;
    logic             REQ_WR;
    logic [Waddr-1:0] REQ_ADDR;
    logic [Wdata-1:0] REQ_DATA;
    logic             RSP_VALID;
    logic             RSP_READY;
    logic [Wdata-1:0] RSP_DATA;
    logic             RSP_ERR;

    modport master (
        output REQ_VALID, REQ_WR, REQ_ADDR, REQ_DATA, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_DATA, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );
endinterface

// File: rtl/bram_rsp_fifo.sv
// Two-entry in-order response buffer with wrapping 1-bit pointers.
// Head entry stays stable until popped.
`timescale 1ns/1ps
module bram_rsp_fifo
    import bram_pkg::*;
#(
    parameter int unsigned W = $bits(rsp_t)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [RSP_DEPTH];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q ^ push_i;
        rptr_d  = rptr_q ^ pop_i;
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push_i) mem_q[wptr_q] <= push_data_i;
        end
    end

    // Upstream ready logic must never let a push land on a full buffer.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i)
            assert (count_q != CNT_W'(RSP_DEPTH));
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/bram_req_adapter.sv
// Valid/ready front end for a single-port, 1-cycle-latency BRAM.
// Define BRAM_REQ_ADAPTER_STATS_EN for RD/WR/ERR request counters.
`timescale 1ns/1ps
module bram_req_adapter
    import bram_pkg::*;
#(
    parameter int unsigned Ncells = 1024,
    parameter int unsigned Wdata  = WDATA,
    parameter int unsigned Waddr  = 32
) (
    input  logic               CLK,
    input  logic               RST,
    bram_req_adapter_if.slave  bus,
    output logic [Waddr-1:0]   MEM_ADDR,
    output logic [Wdata-1:0]   MEM_DIN,
    output logic               MEM_WR,
    input  logic [Wdata-1:0]   MEM_DOUT
`ifdef BRAM_REQ_ADAPTER_STATS_EN
    ,
    output logic [STATS_W-1:0] RD_COUNT,
    output logic [STATS_W-1:0] WR_COUNT,
    output logic [STATS_W-1:0] ERR_COUNT
`endif
);

    localparam logic [Waddr-1:0] LIMIT = Waddr'(Ncells);

    logic             fire, pop, in_range, issue;
    logic             inflight_q, err_q;
    logic [Waddr-1:0] addr_q, addr_d;
    logic [Wdata-1:0] din_q, din_d;
    logic [CNT_W-1:0] count;
    logic [Wdata:0]   push_data, head;

    assign in_range      = bus.REQ_ADDR < LIMIT;
    assign pop           = bus.RSP_VALID & bus.RSP_READY;
    assign bus.RSP_VALID = count != '0;
    assign bus.REQ_READY = ((count + CNT_W'(inflight_q)) < CNT_W'(RSP_DEPTH)) | pop;
    assign fire          = bus.REQ_VALID & bus.REQ_READY;
    assign issue         = fire & in_range;

    // Pins hold their last issued value so the idle memory never writes.
    always_comb begin
        addr_d = addr_q;
        din_d  = din_q;
        if (issue) begin
            addr_d = bus.REQ_ADDR;
            din_d  = bus.REQ_DATA;
        end
    end

    assign MEM_ADDR = addr_d;
    assign MEM_DIN  = din_d;
    assign MEM_WR   = issue & bus.REQ_WR;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q     <= '0;
            din_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            din_q      <= din_d;
            inflight_q <= fire;
            err_q      <= fire & ~in_range;
        end
    end

    assign push_data = err_q ? {{Wdata{1'b0}}, 1'b1} : {MEM_DOUT, 1'b0};

    bram_rsp_fifo #(
        .W (Wdata + 1)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.RSP_DATA = head[Wdata:1];
    assign bus.RSP_ERR  = head[0];

`ifdef BRAM_REQ_ADAPTER_STATS_EN
    logic [STATS_W-1:0] rd_q, rd_d, wr_q, wr_d, errc_q, errc_d;

    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        errc_d = errc_q;
        if (issue && !bus.REQ_WR) rd_d = sat_inc(rd_q);
        if (issue && bus.REQ_WR)  wr_d = sat_inc(wr_q);
        if (fire && !in_range)    errc_d = sat_inc(errc_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q   <= '0;
            wr_q   <= '0;
            errc_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            errc_q <= errc_d;
        end
    end

    assign RD_COUNT  = rd_q;
    assign WR_COUNT  = wr_q;
    assign ERR_COUNT = errc_q;
`endif

endmodule

// File: tb/tb_bram_req_adapter.sv
// Directed bench for bram_req_adapter with a write-through BRAM model.
// Build with BRAM_REQ_ADAPTER_STATS_EN to also exercise the counters.
`timescale 1ns/1ps
module tb_bram_req_adapter;
    import bram_pkg::*;

    localparam int unsigned NC = 1024;
    localparam int unsigned WD = 8;
    localparam int unsigned WA = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_req_adapter_if #(.Waddr(WA), .Wdata(WD)) bus ();

    logic [WA-1:0] mem_addr;
    logic [WD-1:0] mem_din;
    logic [WD-1:0] mem_dout = '0;
    logic          mem_wr;
    logic [WD-1:0] ram [NC];

`ifdef BRAM_REQ_ADAPTER_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, err_cnt;
`endif

    bram_req_adapter #(.Ncells(NC), .Wdata(WD), .Waddr(WA)) dut (
        .CLK      (clk),
        .RST      (rst),
        .bus      (bus),
        .MEM_ADDR (mem_addr),
        .MEM_DIN  (mem_din),
        .MEM_WR   (mem_wr),
        .MEM_DOUT (mem_dout)
`ifdef BRAM_REQ_ADAPTER_STATS_EN
        ,
        .RD_COUNT  (rd_cnt),
        .WR_COUNT  (wr_cnt),
        .ERR_COUNT (err_cnt)
`endif
    );

    // Single-port BRAM, registered DOUT, write-through.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr[9:0]] <= mem_din;
        mem_dout <= mem_wr ? mem_din : ram[mem_addr[9:0]];
    end

    int tests  = 0;
    int failed = 0;

    logic          q_wr   [8];
    logic [WA-1:0] q_addr [8];
    logic [WD-1:0] q_data [8];
    logic [WD-1:0] got_d  [$];
    logic          got_e  [$];
    int            acc_hold;
    int            cyc_used;
    bit            rdy_low;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [WA-1:0] a,
                           input logic [WD-1:0] d);
        q_wr[i]   = w;
        q_addr[i] = a;
        q_data[i] = d;
    endtask

    // Streams n queued requests; RSP_READY low for the first 'hold' cycles.
    task automatic run(input int n, input int hold);
        int acc = 0;
        int cyc = 0;
        got_d.delete();
        got_e.delete();
        acc_hold = 0;
        rdy_low  = 0;
        while ((acc < n || got_d.size() < n) && cyc < 40) begin
            if (cyc == hold) acc_hold = acc;
            bus.REQ_VALID = (acc < n);
            if (acc < n) begin
                bus.REQ_WR   = q_wr[acc];
                bus.REQ_ADDR = q_addr[acc];
                bus.REQ_DATA = q_data[acc];
            end
            bus.RSP_READY = (cyc >= hold);
            #2;
            if (cyc < hold && bus.REQ_VALID && !bus.REQ_READY) rdy_low = 1;
            if (bus.REQ_VALID && bus.REQ_READY) acc++;
            if (bus.RSP_VALID && bus.RSP_READY) begin
                got_d.push_back(bus.RSP_DATA);
                got_e.push_back(bus.RSP_ERR);
            end
            step();
            cyc++;
        end
        bus.REQ_VALID = 1'b0;
        bus.RSP_READY = 1'b1;
        cyc_used = cyc;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (bus.RSP_VALID !== 1'b0) begin failed++; $display("FAIL rst_rsp_valid got %b want 0", bus.RSP_VALID); end
        tests++; if (bus.RSP_DATA !== 8'h00) begin failed++; $display("FAIL rst_rsp_data got %h want 00", bus.RSP_DATA); end
        tests++; if (bus.RSP_ERR !== 1'b0) begin failed++; $display("FAIL rst_rsp_err got %b want 0", bus.RSP_ERR); end
        tests++; if (mem_wr !== 1'b0) begin failed++; $display("FAIL rst_mem_wr got %b want 0", mem_wr); end
        tests++; if (mem_addr !== 32'h0) begin failed++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        tests++; if (mem_din !== 8'h00) begin failed++; $display("FAIL rst_mem_din got %h want 00", mem_din); end
        tests++; if (bus.REQ_READY !== 1'b1) begin failed++; $display("FAIL rst_req_ready got %b want 1", bus.REQ_READY); end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        bus.REQ_VALID = 1'b1;
        bus.REQ_WR    = 1'b1;
        bus.REQ_ADDR  = 32'd3;
        bus.REQ_DATA  = 8'h5A;
        bus.RSP_READY = 1'b1;
        #1;
        tests++; if (bus.REQ_READY !== 1'b1) begin failed++; $display("FAIL wr_ready got %b want 1", bus.REQ_READY); end
        tests++; if (mem_wr !== 1'b1) begin failed++; $display("FAIL wr_mem_wr got %b want 1", mem_wr); end
        tests++; if (mem_addr !== 32'd3) begin failed++; $display("FAIL wr_mem_addr got %h want 3", mem_addr); end
        tests++; if (mem_din !== 8'h5A) begin failed++; $display("FAIL wr_mem_din got %h want 5a", mem_din); end
        step();
        bus.REQ_VALID = 1'b0;
        #1;
        tests++; if (mem_wr !== 1'b0) begin failed++; $display("FAIL wr_idle_wr got %b want 0", mem_wr); end
        tests++; if (mem_addr !== 32'd3) begin failed++; $display("FAIL wr_hold_addr got %h want 3", mem_addr); end
        tests++; if (bus.RSP_VALID !== 1'b0) begin failed++; $display("FAIL wr_early_valid got %b want 0", bus.RSP_VALID); end
        step();
        tests++; if (bus.RSP_VALID !== 1'b1) begin failed++; $display("FAIL wr_rsp_valid got %b want 1", bus.RSP_VALID); end
        tests++; if (bus.RSP_DATA !== 8'h5A) begin failed++; $display("FAIL wr_rsp_data got %h want 5a", bus.RSP_DATA); end
        tests++; if (bus.RSP_ERR !== 1'b0) begin failed++; $display("FAIL wr_rsp_err got %b want 0", bus.RSP_ERR); end
        step();
        tests++; if (bus.RSP_VALID !== 1'b0) begin failed++; $display("FAIL wr_popped got %b want 0", bus.RSP_VALID); end
    endtask

    task automatic test_back_to_back();
        set_req(0, 1'b1, 32'd7, 8'h11);
        set_req(1, 1'b0, 32'd7, 8'h00);
        run(2, 0);
        tests++; if (got_d.size() != 2) begin failed++; $display("FAIL b2b_count got %0d want 2", got_d.size()); end
        for (int i = 0; i < got_d.size(); i++) begin
            tests++; if (got_d[i] !== 8'h11) begin failed++; $display("FAIL b2b_data[%0d] got %h want 11", i, got_d[i]); end
        end
        tests++; if (cyc_used != 4) begin failed++; $display("FAIL b2b_cycles got %0d want 4", cyc_used); end
    endtask

    task automatic test_stream_writes();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'(i), 8'hA0 + 8'(i));
        run(4, 0);
        tests++; if (got_d.size() != 4) begin failed++; $display("FAIL strm_count got %0d want 4", got_d.size()); end
        for (int i = 0; i < got_d.size(); i++) begin
            tests++; if (got_d[i] !== 8'hA0 + 8'(i)) begin failed++; $display("FAIL strm_data[%0d] got %h want %h", i, got_d[i], 8'hA0 + 8'(i)); end
        end
        tests++; if (cyc_used != 6) begin failed++; $display("FAIL strm_cycles got %0d want 6", cyc_used); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'(i), 8'h00);
        run(4, 6);
        tests++; if (acc_hold != 2) begin failed++; $display("FAIL bp_accepted got %0d want 2", acc_hold); end
        tests++; if (rdy_low != 1'b1) begin failed++; $display("FAIL bp_ready_low got %b want 1", rdy_low); end
        tests++; if (got_d.size() != 4) begin failed++; $display("FAIL bp_count got %0d want 4", got_d.size()); end
        for (int i = 0; i < got_d.size(); i++) begin
            tests++; if (got_d[i] !== 8'hA0 + 8'(i)) begin failed++; $display("FAIL bp_data[%0d] got %h want %h", i, got_d[i], 8'hA0 + 8'(i)); end
        end
    endtask

    task automatic test_out_of_range();
        bus.REQ_VALID = 1'b1;
        bus.REQ_WR    = 1'b1;
        bus.REQ_ADDR  = 32'd1024;
        bus.REQ_DATA  = 8'hFF;
        bus.RSP_READY = 1'b1;
        #1;
        tests++; if (bus.REQ_READY !== 1'b1) begin failed++; $display("FAIL oor_ready got %b want 1", bus.REQ_READY); end
        tests++; if (mem_wr !== 1'b0) begin failed++; $display("FAIL oor_mem_wr got %b want 0", mem_wr); end
        tests++; if (mem_addr !== 32'd3) begin failed++; $display("FAIL oor_mem_addr got %h want 3", mem_addr); end
        step();
        bus.REQ_VALID = 1'b0;
        step();
        tests++; if (bus.RSP_VALID !== 1'b1) begin failed++; $display("FAIL oor_valid got %b want 1", bus.RSP_VALID); end
        tests++; if (bus.RSP_DATA !== 8'h00) begin failed++; $display("FAIL oor_data got %h want 00", bus.RSP_DATA); end
        tests++; if (bus.RSP_ERR !== 1'b1) begin failed++; $display("FAIL oor_err got %b want 1", bus.RSP_ERR); end
        step();
        set_req(0, 1'b0, 32'd0, 8'h00);
        set_req(1, 1'b0, 32'hFFFF_FFFF, 8'h00);
        run(2, 0);
        tests++; if (got_d.size() != 2) begin failed++; $display("FAIL oor_rd_count got %0d want 2", got_d.size()); end
        if (got_d.size() == 2) begin
            tests++; if (got_d[0] !== 8'hA0 || got_e[0] !== 1'b0) begin failed++; $display("FAIL oor_rd0 got %h/%b want a0/0", got_d[0], got_e[0]); end
            tests++; if (got_d[1] !== 8'h00 || got_e[1] !== 1'b1) begin failed++; $display("FAIL oor_max got %h/%b want 00/1", got_d[1], got_e[1]); end
        end
    endtask

    task automatic test_reset_mid();
        bit stale = 0;
        bus.RSP_READY = 1'b0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_WR    = 1'b0;
        bus.REQ_ADDR  = 32'd1;
        step();
        bus.REQ_ADDR  = 32'd2;
        step();
        bus.REQ_VALID = 1'b0;
        #1;
        tests++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 8'hA1) begin failed++; $display("FAIL mid_pre got %b/%h want 1/a1", bus.RSP_VALID, bus.RSP_DATA); end
        rst = 1'b1;
        #1;
        tests++; if (bus.RSP_VALID !== 1'b0) begin failed++; $display("FAIL mid_async_valid got %b want 0", bus.RSP_VALID); end
        tests++; if (bus.RSP_DATA !== 8'h00) begin failed++; $display("FAIL mid_async_data got %h want 00", bus.RSP_DATA); end
        step();
        rst = 1'b0;
        bus.RSP_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.RSP_VALID !== 1'b0) stale = 1;
        end
        tests++; if (stale !== 1'b0) begin failed++; $display("FAIL mid_stale got %b want 0", stale); end
        set_req(0, 1'b0, 32'd2, 8'h00);
        run(1, 0);
        tests++; if (got_d.size() != 1) begin failed++; $display("FAIL mid_after_count got %0d want 1", got_d.size()); end
        if (got_d.size() == 1) begin
            tests++; if (got_d[0] !== 8'hA2) begin failed++; $display("FAIL mid_after_data got %h want a2", got_d[0]); end
        end
        tests++; if (cyc_used != 3) begin failed++; $display("FAIL mid_after_lat got %0d want 3", cyc_used); end
    endtask

`ifdef BRAM_REQ_ADAPTER_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        tests++; if (rd_cnt !== 16'd0) begin failed++; $display("FAIL st_rst_rd got %0d want 0", rd_cnt); end
        set_req(0, 1'b0, 32'd0, 8'h00);
        set_req(1, 1'b0, 32'd1, 8'h00);
        set_req(2, 1'b0, 32'd2, 8'h00);
        set_req(3, 1'b1, 32'd5, 8'h55);
        set_req(4, 1'b1, 32'd6, 8'h66);
        set_req(5, 1'b0, 32'd2000, 8'h00);
        run(6, 0);
        tests++; if (rd_cnt !== 16'd3) begin failed++; $display("FAIL st_rd got %0d want 3", rd_cnt); end
        tests++; if (wr_cnt !== 16'd2) begin failed++; $display("FAIL st_wr got %0d want 2", wr_cnt); end
        tests++; if (err_cnt !== 16'd1) begin failed++; $display("FAIL st_err got %0d want 1", err_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < NC; i++) ram[i] = '0;
        bus.REQ_VALID = 1'b0;
        bus.REQ_WR    = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.REQ_DATA  = '0;
        bus.RSP_READY = 1'b0;
        test_reset();
        test_write();
        test_back_to_back();
        test_stream_writes();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
`ifdef BRAM_REQ_ADAPTER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
